// File: rtl/alu_seq_if.sv
// Operand/result handshake bundle between the operand source, alu_seq and the result consumer.
interface alu_seq_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic [2:0]       op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             overflow;
    logic             zero;
    logic             negative;
    logic             busy;

    // Source/consumer side
    modport master (
        output in_valid, a, b, cin, op, out_ready,
        input  in_ready, out_valid, result, carry, overflow, zero, negative, busy
    );

    // ALU side
    modport slave (
        input  in_valid, a, b, cin, op, out_ready,
        output in_ready, out_valid, result, carry, overflow, zero, negative, busy
    );
endinterface

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle arithmetic/logic, bit-serial shifts, registered result stage.
module alu_seq #(
    parameter int unsigned WIDTH = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    alu_seq_if.slave   bus
);
    localparam int unsigned SHW = $clog2(WIDTH);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SLT = 3'b101;
    localparam logic [2:0] OP_SLL = 3'b110;

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             carry_q, carry_d;
    logic             overflow_q, overflow_d;
    logic             zero_q, zero_d;
    logic             negative_q, negative_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;
    logic [SHW-1:0]   count_q, count_d;
    logic             sll_q, sll_d;

    logic             in_ready_c;
    logic             accept_c;
    logic [WIDTH-1:0] b_op_c;
    logic [WIDTH:0]   sum_c;
    logic [SHW-1:0]   shamt_c;
    logic             slt_c;

    // Ready depends only on state and consumer back-pressure, never on in_valid
    assign in_ready_c = (state_q == IDLE) || ((state_q == DONE) && bus.out_ready);
    assign accept_c   = bus.in_valid && in_ready_c;

    // Shared adder (SUB is a + ~b + cin) and operand decode
    always_comb begin
        b_op_c  = (bus.op == OP_SUB) ? ~bus.b : bus.b;
        sum_c   = {1'b0, bus.a} + {1'b0, b_op_c} + {{WIDTH{1'b0}}, bus.cin};
        shamt_c = bus.b[SHW-1:0];
        slt_c   = $signed(bus.a) < $signed(bus.b);
    end

    // Next-state: serial shift step in EXEC, else capture on accept, else retire in DONE
    always_comb begin
        state_d     = state_q;
        result_d    = result_q;
        carry_d     = carry_q;
        overflow_d  = overflow_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        count_d     = count_q;
        sll_d       = sll_q;

        if (state_q == EXEC) begin
            if (sll_q) begin
                carry_d  = result_q[WIDTH-1];
                result_d = {result_q[WIDTH-2:0], 1'b0};
            end else begin
                carry_d  = result_q[0];
                result_d = {result_q[WIDTH-1], result_q[WIDTH-1:1]};
            end
            count_d = count_q - SHW'(1);
            if (count_q == SHW'(1)) begin
                state_d     = DONE;
                out_valid_d = 1'b1;
                busy_d      = 1'b0;
            end
        end else if (accept_c) begin
            carry_d     = 1'b0;
            overflow_d  = 1'b0;
            state_d     = DONE;
            out_valid_d = 1'b1;
            busy_d      = 1'b0;
            unique case (bus.op)
                OP_ADD, OP_SUB: begin
                    result_d   = sum_c[WIDTH-1:0];
                    carry_d    = sum_c[WIDTH];
                    overflow_d = (bus.a[WIDTH-1] == b_op_c[WIDTH-1]) &&
                                 (sum_c[WIDTH-1] != bus.a[WIDTH-1]);
                end
                OP_AND:  result_d = bus.a & bus.b;
                OP_OR:   result_d = bus.a | bus.b;
                OP_XOR:  result_d = bus.a ^ bus.b;
                OP_SLT:  result_d = {{(WIDTH-1){1'b0}}, slt_c};
                default: begin
                    // SLL / SRA: zero shift amount completes immediately with a passed through
                    result_d = bus.a;
                    sll_d    = (bus.op == OP_SLL);
                    if (shamt_c != '0) begin
                        count_d     = shamt_c;
                        state_d     = EXEC;
                        out_valid_d = 1'b0;
                        busy_d      = 1'b1;
                    end
                end
            endcase
        end else if ((state_q == DONE) && bus.out_ready) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
        end

        zero_d     = (result_d == '0);
        negative_d = result_d[WIDTH-1];
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            result_q    <= '0;
            carry_q     <= 1'b0;
            overflow_q  <= 1'b0;
            zero_q      <= 1'b0;
            negative_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            count_q     <= '0;
            sll_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            result_q    <= result_d;
            carry_q     <= carry_d;
            overflow_q  <= overflow_d;
            zero_q      <= zero_d;
            negative_q  <= negative_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            count_q     <= count_d;
            sll_q       <= sll_d;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.carry     = carry_q;
    assign bus.overflow  = overflow_q;
    assign bus.zero      = zero_q;
    assign bus.negative  = negative_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: expected results queued at issue, checked when out_valid appears.
module tb_alu_seq;
    localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, AND_ = 3'd2, OR_ = 3'd3;
    localparam logic [2:0] XOR_ = 3'd4, SLT = 3'd5, SLL = 3'd6, SRA = 3'd7;

    typedef struct {
        logic [31:0] res;
        logic        c;
        logic        v;
        logic        z;
        logic        n;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_vec = 0;
    int   n_err = 0;
    exp_t sb[$];

    alu_seq_if #(.WIDTH(32)) bus ();

    alu_seq #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model written from the arithmetic definitions (signed/unsigned integer ranges)
    function automatic exp_t model(logic [2:0] op, logic [31:0] a, logic [31:0] b, logic cin);
        exp_t    e;
        longint  ua, ub, us, sa, sb_, ss;
        int      sh;
        e.res = '0; e.c = 1'b0; e.v = 1'b0;
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        sa = longint'($signed(a));
        sb_ = longint'($signed(b));
        sh = int'(b[4:0]);
        case (op)
            ADD: begin
                us = ua + ub + longint'(cin);
                ss = sa + sb_ + longint'(cin);
                e.res = us[31:0];
                e.c = (us > 64'sh0FFFF_FFFF);
                e.v = (ss > 64'sh7FFF_FFFF) || (ss < -64'sh8000_0000);
            end
            SUB: begin
                us = ua + (64'sh0FFFF_FFFF - ub) + longint'(cin);
                ss = sa - sb_ - 1 + longint'(cin);
                e.res = us[31:0];
                e.c = (us > 64'sh0FFFF_FFFF);
                e.v = (ss > 64'sh7FFF_FFFF) || (ss < -64'sh8000_0000);
            end
            AND_: e.res = a & b;
            OR_:  e.res = a | b;
            XOR_: e.res = a ^ b;
            SLT:  e.res = (sa < sb_) ? 32'd1 : 32'd0;
            SLL: begin
                e.res = a << sh;
                if (sh != 0) e.c = a[32 - sh];
            end
            default: begin
                e.res = $signed(a) >>> sh;
                if (sh != 0) e.c = a[sh - 1];
            end
        endcase
        e.z = (e.res == 32'd0);
        e.n = e.res[31];
        return e;
    endfunction

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present an op, wait (bounded) for in_ready, queue its expectation and take the accept edge
    task automatic issue(logic [2:0] op, logic [31:0] a, logic [31:0] b, logic cin);
        int w = 0;
        bus.in_valid = 1'b1;
        bus.op = op;
        bus.a = a;
        bus.b = b;
        bus.cin = cin;
        while (!bus.in_ready && w < 64) begin
            tick();
            w++;
        end
        check("in_ready_wait", 64'(bus.in_ready), 64'd1);
        sb.push_back(model(op, a, b, cin));
        tick();
        bus.in_valid = 1'b0;
        bus.a = $urandom;
        bus.b = $urandom;
        bus.op = 3'($urandom);
        bus.cin = 1'($urandom);
    endtask

    // Wait for out_valid; exp_edges = clock edges after the accept edge before out_valid shows
    task automatic collect(string tag, int exp_edges);
        int   edges = 0;
        exp_t e;
        while (!bus.out_valid && edges < 64) begin
            check({tag, "_busy"}, 64'(bus.busy), 64'd1);
            check({tag, "_in_ready_exec"}, 64'(bus.in_ready), 64'd0);
            tick();
            edges++;
        end
        check({tag, "_lat"}, 64'(edges), 64'(exp_edges));
        if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s_sb: got output with empty scoreboard", tag);
        end else begin
            e = sb.pop_front();
            check({tag, "_res"}, 64'(bus.result), 64'(e.res));
            check({tag, "_carry"}, 64'(bus.carry), 64'(e.c));
            check({tag, "_ovf"}, 64'(bus.overflow), 64'(e.v));
            check({tag, "_zero"}, 64'(bus.zero), 64'(e.z));
            check({tag, "_neg"}, 64'(bus.negative), 64'(e.n));
            check({tag, "_busy_done"}, 64'(bus.busy), 64'd0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t hold;
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        bus.a = '0;
        bus.b = '0;
        bus.cin = 1'b0;
        bus.op = '0;
        tick();
        tick();
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_result", 64'(bus.result), 64'd0);
        check("rst_flags", 64'({bus.carry, bus.overflow, bus.zero, bus.negative, bus.busy}), 64'd0);
        rst_n = 1'b1;
        tick();

        // Carry-out and zero
        issue(ADD, 32'hFFFF_FFFF, 32'd1, 1'b0);
        collect("add_wrap", 0);
        // Signed overflow on subtract
        issue(SUB, 32'h8000_0000, 32'd1, 1'b1);
        collect("sub_ovf", 0);
        issue(SLT, 32'hFFFF_FFFF, 32'd1, 1'b0);
        collect("slt", 0);
        // Multi-cycle shifts
        issue(SLL, 32'h2000_0001, 32'd3, 1'b0);
        collect("sll3", 3);
        issue(SRA, 32'h8000_0000, 32'd31, 1'b0);
        collect("sra31", 31);
        issue(SRA, 32'h8000_0000, 32'd32, 1'b0);
        collect("sra_sh0", 0);
        tick();

        // Back-pressure: result held, then consumed on the same edge a new op is accepted
        bus.out_ready = 1'b0;
        issue(ADD, 32'h1234_5678, 32'h8111_1111, 1'b1);
        collect("bp", 0);
        hold = model(ADD, 32'h1234_5678, 32'h8111_1111, 1'b1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_hold_res", 64'(bus.result), 64'(hold.res));
            check("bp_hold_flags", 64'({bus.carry, bus.overflow, bus.zero, bus.negative}),
                  64'({hold.c, hold.v, hold.z, hold.n}));
            check("bp_out_valid", 64'(bus.out_valid), 64'd1);
            check("bp_in_ready", 64'(bus.in_ready), 64'd0);
        end
        bus.out_ready = 1'b1;
        #0;
        check("b2b_in_ready", 64'(bus.in_ready), 64'd1);
        issue(XOR_, 32'hF0F0_F0F0, 32'hFFFF_FFFF, 1'b0);
        collect("b2b_xor", 0);

        // Random mix, short shifts, back-to-back
        for (int i = 0; i < 24; i++) begin
            logic [2:0]  op;
            logic [31:0] a, b;
            int          exp_edges;
            op = 3'($urandom_range(0, 7));
            a = $urandom;
            b = (op >= SLL) ? 32'($urandom_range(0, 7)) : $urandom;
            if (i % 6 == 0) a = 32'h7FFF_FFFF;
            exp_edges = (op >= SLL) ? int'(b[4:0]) : 0;
            issue(op, a, b, 1'($urandom));
            collect("rand", exp_edges);
        end
        tick();

        // Reset during EXEC aborts the shift
        issue(SLL, 32'h0000_0001, 32'd20, 1'b0);
        sb.delete();
        for (int i = 0; i < 5; i++) tick();
        check("mid_busy", 64'(bus.busy), 64'd1);
        check("mid_result_nonzero", 64'(bus.result != 32'd0), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", 64'(bus.out_valid), 64'd0);
        check("abort_busy", 64'(bus.busy), 64'd0);
        check("abort_result", 64'(bus.result), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
        issue(ADD, 32'd2, 32'd3, 1'b0);
        collect("post_rst_add", 0);
        tick();
        check("sb_drained", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
